// File: rtl/coin_pkg.sv
// Shared types and helpers for the coin acceptor: FSM state encoding,
// denomination codes and the code-to-units decoder.
package coin_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    GRANT,
    WAIT_ACK,
    REFUND
  } coin_state_t;

  localparam logic [1:0] COIN_INV = 2'd0;
  localparam logic [1:0] COIN_1   = 2'd1;
  localparam logic [1:0] COIN_2   = 2'd2;
  localparam logic [1:0] COIN_5   = 2'd3;

  // Denomination code to credit units; the invalid code is worth nothing.
  function automatic logic [2:0] coin_units(input logic [1:0] code);
    logic [2:0] units;
    case (code)
      COIN_1:  units = 3'd1;
      COIN_2:  units = 3'd2;
      COIN_5:  units = 3'd5;
      default: units = 3'd0;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/coin_timeout_ctr.sv
// Idle/ack timeout counter shared by COLLECT and WAIT_ACK. expired_o flags
// the enabled cycle in which the count reaches TIMEOUT, so the owner can
// leave its state on the following edge.
module coin_timeout_ctr #(
  parameter int TIMEOUT = 1000,
  parameter int TO_W    = 10
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q;

  // Count enabled cycles; clear has priority over enable.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)   cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= cnt_q + 1'b1;
  end

  assign expired_o = en_i && (cnt_q >= LAST);

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: accumulates credit from coin strobes, issues a
// grant pulse to the locker at PRICE, waits for the unlocked ack and pays
// refunds on cancel or timeout. All outputs are registered, so each
// decision taken in cycle N (including a reject) is seen in cycle N+1.
// Build option: CHANGE_RETURN_EN pays a post-grant remainder as change
// instead of keeping it as credit.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int PRICE    = 5,
  parameter int CREDIT_W = 4,
  parameter int TIMEOUT  = 1000,
  parameter int TO_W     = 10
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                coin_valid_i,
  input  logic [1:0]          coin_value_i,
  input  logic                cancel_i,
  input  logic                unlocked_i,
  output logic                coin_o,
  output logic                reject_o,
  output logic                refund_valid_o,
  output logic [CREDIT_W-1:0] refund_amt_o,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                fault_o
);

  localparam logic [CREDIT_W:0]   PRICE_W = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  coin_state_t         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] rfa_q, rfa_d;
  logic                coin_q, coin_d;
  logic                reject_q, reject_d;
  logic                rfv_q, rfv_d;
  logic                fault_q, fault_d;
  logic                to_clr, to_en, to_exp;
  logic [CREDIT_W:0]   value, sum;
  logic                coin_ok;

  coin_timeout_ctr #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_to (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (to_clr),
    .en_i      (to_en),
    .expired_o (to_exp)
  );

  // Extra top bit on the sum catches accumulator overflow.
  assign value   = (CREDIT_W+1)'(coin_units(coin_value_i));
  assign sum     = {1'b0, credit_q} + value;
  assign coin_ok = coin_valid_i && (coin_value_i != COIN_INV);

  // Next-state, credit and output decisions.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = 1'b0;
    fault_d  = 1'b0;
    to_clr   = 1'b1;
    to_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (coin_valid_i) begin
          if (!coin_ok) begin
            reject_d = 1'b1;
          end else begin
            credit_d = value[CREDIT_W-1:0];
            state_d  = (value >= PRICE_W) ? GRANT : COLLECT;
          end
        end
      end
      COLLECT: begin
        to_clr = 1'b0;
        to_en  = 1'b1;
        if (cancel_i) begin
          reject_d = coin_valid_i;
          state_d  = REFUND;
        end else if (coin_ok && !sum[CREDIT_W]) begin
          credit_d = sum[CREDIT_W-1:0];
          to_clr   = 1'b1;
          if (sum >= PRICE_W) state_d = GRANT;
        end else begin
          // Overflowing or invalid coins bounce; credit saturates by rejection.
          reject_d = coin_valid_i;
          if (to_exp) state_d = REFUND;
        end
      end
      GRANT: begin
        reject_d = coin_valid_i;
        credit_d = credit_q - PRICE_C;
        state_d  = WAIT_ACK;
      end
      WAIT_ACK: begin
        reject_d = coin_valid_i;
        to_clr   = 1'b0;
        to_en    = 1'b1;
        if (unlocked_i) begin
          to_clr = 1'b1;
          if (credit_q == '0) state_d = IDLE;
`ifdef CHANGE_RETURN_EN
          else                state_d = REFUND;
`else
          else                state_d = COLLECT;
`endif
        end else if (to_exp) begin
          // Locker never opened: give the price back and refund everything.
          credit_d = credit_q + PRICE_C;
          fault_d  = 1'b1;
          state_d  = REFUND;
        end
      end
      REFUND: begin
        reject_d = coin_valid_i;
        credit_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    coin_d = (state_d == GRANT);
    rfv_d  = (state_d == REFUND);
    rfa_d  = rfv_d ? credit_d : '0;
  end

  // State, credit and registered output pulses.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      credit_q <= '0;
      coin_q   <= 1'b0;
      reject_q <= 1'b0;
      rfv_q    <= 1'b0;
      rfa_q    <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      coin_q   <= coin_d;
      reject_q <= reject_d;
      rfv_q    <= rfv_d;
      rfa_q    <= rfa_d;
      fault_q  <= fault_d;
    end
  end

  assign coin_o         = coin_q;
  assign reject_o       = reject_q;
  assign refund_valid_o = rfv_q;
  assign refund_amt_o   = rfa_q;
  assign credit_o       = credit_q;
  assign fault_o        = fault_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: a vector table for the single-cycle
// behaviour plus hand sequences for timeouts and accumulator saturation.
// Outputs are compared one cycle after the inputs are applied.
module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cv = 1'b0;
  logic [1:0] code = 2'd0;
  logic       can = 1'b0;
  logic       unl = 1'b0;

  logic       a_coin, a_rej, a_rfv, a_flt;
  logic [3:0] a_rfa, a_cr;
  logic       b_coin, b_rej, b_rfv, b_flt;
  logic [3:0] b_rfa, b_cr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  coin_acceptor #(.PRICE(5), .CREDIT_W(4), .TIMEOUT(16), .TO_W(5)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .coin_valid_i(cv), .coin_value_i(code),
    .cancel_i(can), .unlocked_i(unl), .coin_o(a_coin), .reject_o(a_rej),
    .refund_valid_o(a_rfv), .refund_amt_o(a_rfa), .credit_o(a_cr), .fault_o(a_flt));

  // Second instance with PRICE = 15 so credit can reach the top of the range.
  coin_acceptor #(.PRICE(15), .CREDIT_W(4), .TIMEOUT(16), .TO_W(5)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .coin_valid_i(cv), .coin_value_i(code),
    .cancel_i(can), .unlocked_i(unl), .coin_o(b_coin), .reject_o(b_rej),
    .refund_valid_o(b_rfv), .refund_amt_o(b_rfa), .credit_o(b_cr), .fault_o(b_flt));

  typedef struct {
    string      name;
    logic       rst_n, v;
    logic [1:0] code;
    logic       can, unl;
    logic       coin, rej, rfv;
    logic [3:0] rfa, cr;
    logic       flt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(string nm, logic r, logic v, logic [1:0] c, logic cn, logic u,
                              logic eco, logic erj, logic erv, logic [3:0] era,
                              logic [3:0] ecr, logic efl);
    vec_t t;
    t.name = nm; t.rst_n = r; t.v = v; t.code = c; t.can = cn; t.unl = u;
    t.coin = eco; t.rej = erj; t.rfv = erv; t.rfa = era; t.cr = ecr; t.flt = efl;
    tbl.push_back(t);
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1ns after the rise.
  task automatic apply(input logic r, input logic v, input logic [1:0] c,
                       input logic cn, input logic u);
    @(negedge clk);
    rst_n = r; cv = v; code = c; can = cn; unl = u;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got coin/rej/rfv/rfa/credit/fault=%b_%b_%b_%0d_%0d_%b want %b_%b_%b_%0d_%0d_%b",
               nm, act[11], act[10], act[9], act[8:5], act[4:1], act[0],
               exp[11], exp[10], exp[9], exp[8:5], exp[4:1], exp[0]);
    end
  endtask

  function automatic logic [11:0] pk(logic co, logic rj, logic rv, logic [3:0] ra,
                                     logic [3:0] cr, logic fl);
    return {co, rj, rv, ra, cr, fl};
  endfunction

  task automatic chk_a(input string nm, input logic co, input logic rj, input logic rv,
                       input logic [3:0] ra, input logic [3:0] cr, input logic fl);
    chk(nm, pk(a_coin, a_rej, a_rfv, a_rfa, a_cr, a_flt), pk(co, rj, rv, ra, cr, fl));
  endtask

  task automatic chk_b(input string nm, input logic co, input logic rj, input logic rv,
                       input logic [3:0] ra, input logic [3:0] cr, input logic fl);
    chk(nm, pk(b_coin, b_rej, b_rfv, b_rfa, b_cr, b_flt), pk(co, rj, rv, ra, cr, fl));
  endtask

  initial begin
    //   name          rst v  cd can unl  coin rej rfv rfa cr flt
    add("reset0",      0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0);
    add("reset1",      0, 1, 3, 1, 1,    0, 0, 0, 0, 0, 0);
    // 2 + 2 + 1 reaches PRICE, grant, ack with nothing left
    add("t1_c2a",      1, 1, 2, 0, 0,    0, 0, 0, 0, 2, 0);
    add("t1_c2b",      1, 1, 2, 0, 0,    0, 0, 0, 0, 4, 0);
    add("t1_c1",       1, 1, 1, 0, 0,    1, 0, 0, 0, 5, 0);
    add("t1_grant",    1, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0);
    add("t1_ack",      1, 0, 0, 0, 1,    0, 0, 0, 0, 0, 0);
    add("t1_can_idle", 1, 0, 0, 1, 0,    0, 0, 0, 0, 0, 0);
    // invalid code, then a 5 from IDLE grants at once; coin during GRANT bounces
    add("t2_inv",      1, 1, 0, 0, 0,    0, 1, 0, 0, 0, 0);
    add("t2_c5",       1, 1, 3, 0, 0,    1, 0, 0, 0, 5, 0);
    add("t2_grant_cn", 1, 1, 1, 0, 0,    0, 1, 0, 0, 0, 0);
    add("t2_ack",      1, 0, 0, 0, 1,    0, 0, 0, 0, 0, 0);
    // cancel refunds; cancel with a coin rejects the coin
    add("t3_c2",       1, 1, 2, 0, 0,    0, 0, 0, 0, 2, 0);
    add("t3_cancel",   1, 0, 0, 1, 0,    0, 0, 1, 2, 2, 0);
    add("t3_after",    1, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0);
    add("t3_c1",       1, 1, 1, 0, 0,    0, 0, 0, 0, 1, 0);
    add("t3_can_coin", 1, 1, 2, 1, 0,    0, 1, 1, 1, 1, 0);
    add("t3_after2",   1, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0);
    // 2 + 5 = 7: grant leaves remainder 2
    add("t4_c2",       1, 1, 2, 0, 0,    0, 0, 0, 0, 2, 0);
    add("t4_c5",       1, 1, 3, 0, 0,    1, 0, 0, 0, 7, 0);
    add("t4_grant",    1, 0, 0, 0, 0,    0, 0, 0, 0, 2, 0);
`ifdef CHANGE_RETURN_EN
    add("t4_ack",      1, 0, 0, 0, 1,    0, 0, 1, 2, 2, 0);
    add("t4_cancel",   1, 0, 0, 1, 0,    0, 0, 0, 0, 0, 0);
`else
    add("t4_ack",      1, 0, 0, 0, 1,    0, 0, 0, 0, 2, 0);
    add("t4_cancel",   1, 0, 0, 1, 0,    0, 0, 1, 2, 2, 0);
`endif
    add("t4_after",    1, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0);
    // synchronous reset in the middle of COLLECT drops the credit silently
    add("t6_c2",       1, 1, 2, 0, 0,    0, 0, 0, 0, 2, 0);
    add("t6_rst",      0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0);
    add("t6_post_can", 1, 0, 0, 1, 0,    0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      apply(tbl[i].rst_n, tbl[i].v, tbl[i].code, tbl[i].can, tbl[i].unl);
      chk_a(tbl[i].name, tbl[i].coin, tbl[i].rej, tbl[i].rfv, tbl[i].rfa, tbl[i].cr, tbl[i].flt);
    end

    // Collect timeout: 16 idle cycles after a coin refunds it.
    apply(1, 1, 1, 0, 0);
    chk_a("to_c1", 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 16; k++) begin
      apply(1, 0, 0, 0, 0);
      if (k < 16) chk_a($sformatf("to_wait%0d", k), 0, 0, 0, 0, 1, 0);
      else        chk_a("to_refund", 0, 0, 1, 1, 1, 0);
    end
    apply(1, 0, 0, 0, 0);
    chk_a("to_after", 0, 0, 0, 0, 0, 0);

    // Ack timeout: locker never opens; price restored, fault and full refund.
    apply(1, 1, 2, 0, 0);
    chk_a("fa_c2", 0, 0, 0, 0, 2, 0);
    apply(1, 1, 3, 0, 0);
    chk_a("fa_c5", 1, 0, 0, 0, 7, 0);
    apply(1, 0, 0, 0, 0);
    chk_a("fa_grant", 0, 0, 0, 0, 2, 0);
    for (int k = 1; k <= 16; k++) begin
      apply(1, k == 3, 2'd2, 0, 0);
      if (k < 16) chk_a($sformatf("fa_wait%0d", k), 0, k == 3, 0, 0, 2, 0);
      else        chk_a("fa_fault", 0, 0, 1, 7, 7, 1);
    end
    apply(1, 0, 0, 0, 0);
    chk_a("fa_after", 0, 0, 0, 0, 0, 0);

    // Saturation on the PRICE = 15 instance: 5+5+2+2 = 14, a further 2 bounces.
    apply(0, 0, 0, 0, 0);
    chk_b("sat_reset", 0, 0, 0, 0, 0, 0);
    apply(1, 1, 3, 0, 0);
    chk_b("sat_c5a", 0, 0, 0, 0, 5, 0);
    apply(1, 1, 3, 0, 0);
    chk_b("sat_c5b", 0, 0, 0, 0, 10, 0);
    apply(1, 1, 2, 0, 0);
    chk_b("sat_c2a", 0, 0, 0, 0, 12, 0);
    apply(1, 1, 2, 0, 0);
    chk_b("sat_c2b", 0, 0, 0, 0, 14, 0);
    apply(1, 1, 2, 0, 0);
    chk_b("sat_overflow", 0, 1, 0, 0, 14, 0);
    apply(1, 1, 1, 0, 0);
    chk_b("sat_fill15", 1, 0, 0, 0, 15, 0);
    apply(1, 0, 0, 0, 0);
    chk_b("sat_grant", 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
